// File: rtl/tft_pattern_gen.sv
// Animated test-pattern source for tft_driver: colour bars, gradient, checkerboard
// and a bouncing box, with one cycle of pixel latency and per-frame state updates.
module tft_pattern_gen #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic [1:0]  pattern_sel,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        new_frame,
    input  logic        data_ena,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [15:0] frame_count,
    output logic [9:0]  box_x,
    output logic [8:0]  box_y
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int X_MAX = H_ACTIVE - BOX_SIZE;
    localparam int Y_MAX = V_ACTIVE - BOX_SIZE;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    logic [1:0]  pat;
    logic        dir_x, dir_y;   // 0 = moving +, 1 = moving -
    logic [2:0]  bar;
    logic        in_box;
    rgb_t        pix;
    logic [10:0] x_inc;
    logic [9:0]  y_inc;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        ndx, ndy;

    // Bar index by constant compares; each later match overrides the earlier one.
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++)
            if (x >= 10'(i * BAR_W)) bar = 3'(i);
    end

    assign in_box = ({1'b0, x} >= {1'b0, box_x}) &&
                    ({1'b0, x} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                    ({1'b0, y} >= {1'b0, box_y}) &&
                    ({1'b0, y} <  {1'b0, box_y} + 10'(BOX_SIZE));

    always_comb begin
        pix = '0;
        if (data_ena && (x < 10'(H_ACTIVE)) && (y < 9'(V_ACTIVE))) begin
            unique case (pat)
                2'd0: pix = '{r: {8{~bar[1]}}, g: {8{~bar[2]}}, b: {8{~bar[0]}}};
                2'd1: pix = '{r: x[8:1], g: y[8:1], b: frame_count[7:0]};
                2'd2: pix = (x[4] ^ y[4] ^ frame_count[5]) ? 24'hFFFFFF : 24'h000000;
                2'd3: pix = in_box ? 24'hFF0000 : 24'h404040;
            endcase
        end
    end

    // Box stepping with a spare top bit so the increment never wraps.
    always_comb begin
        x_inc = {1'b0, box_x} + 11'(BOX_STEP);
        y_inc = {1'b0, box_y} + 10'(BOX_STEP);
        nx    = box_x;
        ndx   = dir_x;
        ny    = box_y;
        ndy   = dir_y;
        if (!dir_x) begin
            if (x_inc >= 11'(X_MAX)) begin nx = 10'(X_MAX); ndx = 1'b1; end
            else                            nx = x_inc[9:0];
        end else begin
            if (box_x <= 10'(BOX_STEP)) begin nx = '0; ndx = 1'b0; end
            else                               nx = box_x - 10'(BOX_STEP);
        end
        if (!dir_y) begin
            if (y_inc >= 10'(Y_MAX)) begin ny = 9'(Y_MAX); ndy = 1'b1; end
            else                            ny = y_inc[8:0];
        end else begin
            if (box_y <= 9'(BOX_STEP)) begin ny = '0; ndy = 1'b0; end
            else                              ny = box_y - 9'(BOX_STEP);
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            {red, green, blue} <= '0;
            frame_count        <= '0;
            pat                <= '0;
            box_x              <= '0;
            box_y              <= '0;
            dir_x              <= 1'b0;
            dir_y              <= 1'b0;
        end else begin
            {red, green, blue} <= pix;
            if (new_frame) begin
                frame_count <= frame_count + 16'd1;
                pat         <= pattern_sel;
                box_x       <= nx;
                box_y       <= ny;
                dir_x       <= ndx;
                dir_y       <= ndy;
            end
        end
    end
endmodule

// File: tb/tb_tft_pattern_gen.sv
// Scoreboard bench for tft_pattern_gen: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_tft_pattern_gen;
    localparam int H_ACTIVE = 480;
    localparam int V_ACTIVE = 272;
    localparam int BOX_SIZE = 32;
    localparam int BOX_STEP = 2;

    logic        cclk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        new_frame = 1'b0;
    logic        data_ena = 1'b0;
    logic [7:0]  red, green, blue;
    logic [15:0] frame_count;
    logic [9:0]  box_x;
    logic [8:0]  box_y;

    always #5 cclk = ~cclk;

    tft_pattern_gen #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
                      .BOX_SIZE(BOX_SIZE), .BOX_STEP(BOX_STEP)) dut (
        .cclk(cclk), .rst(rst), .pattern_sel(pattern_sel), .x(x), .y(y),
        .new_frame(new_frame), .data_ena(data_ena), .red(red), .green(green),
        .blue(blue), .frame_count(frame_count), .box_x(box_x), .box_y(box_y)
    );

    typedef struct {
        logic [23:0] rgb;
        logic [15:0] fc;
        logic [9:0]  bx;
        logic [8:0]  by;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference state: positions as plain ints, velocity as +1/-1.
    int m_fc = 0, m_pat = 0, m_bx = 0, m_by = 0, m_vx = 1, m_vy = 1;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] model_rgb(int px, int py, bit de);
        if (!de || px >= H_ACTIVE || py >= V_ACTIVE) return 24'h0;
        case (m_pat)
            0: return bars[px / (H_ACTIVE / 8)];
            1: return {8'((px / 2) % 256), 8'((py / 2) % 256), 8'(m_fc % 256)};
            2: return ((((px / 16) ^ (py / 16) ^ (m_fc / 32)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
            default: return (px >= m_bx && px < m_bx + BOX_SIZE &&
                             py >= m_by && py < m_by + BOX_SIZE) ? 24'hFF0000 : 24'h404040;
        endcase
    endfunction

    task automatic step_axis(inout int p, inout int v, input int lim);
        if (v > 0) begin
            if (p + BOX_STEP >= lim) begin p = lim; v = -1; end
            else p = p + BOX_STEP;
        end else begin
            if (p <= BOX_STEP) begin p = 0; v = 1; end
            else p = p - BOX_STEP;
        end
    endtask

    task automatic cyc(bit r, bit nf, int px, int py, bit de);
        exp_t e;
        @(negedge cclk);
        rst = r; new_frame = nf; x = 10'(px); y = 9'(py); data_ena = de;
        e.rgb = r ? 24'h0 : model_rgb(px, py, de);
        if (r) begin
            m_fc = 0; m_pat = 0; m_bx = 0; m_by = 0; m_vx = 1; m_vy = 1;
        end else if (nf) begin
            m_fc  = (m_fc + 1) % 65536;
            m_pat = int'(pattern_sel);
            step_axis(m_bx, m_vx, H_ACTIVE - BOX_SIZE);
            step_axis(m_by, m_vy, V_ACTIVE - BOX_SIZE);
        end
        e.fc = 16'(m_fc); e.bx = 10'(m_bx); e.by = 9'(m_by);
        q.push_back(e);
    endtask

    task automatic rand_pix();
        cyc(0, 0, $urandom_range(0, 600), $urandom_range(0, 300), 1'($urandom_range(0, 1)));
    endtask

    task automatic frame_rand();
        cyc(0, 1, $urandom_range(0, 600), $urandom_range(0, 300), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 2)) rand_pix();
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge cclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
                chk("frame_count", 32'(frame_count), 32'(e.fc));
                chk("box_x", 32'(box_x), 32'(e.bx));
                chk("box_y", 32'(box_y), 32'(e.by));
                chk("box_x_bound", 32'(box_x <= 10'(H_ACTIVE - BOX_SIZE)), 32'd1);
            end
        end
    end

    initial begin : stim
        int xs [6] = '{0, 59, 60, 300, 479, 480};
        int bx, by;
        repeat (3) cyc(1, 0, 10, 10, 1);
        cyc(0, 0, 10, 10, 1);
        // colour bars
        pattern_sel = 2'd0;
        cyc(0, 1, 0, 0, 0);
        foreach (xs[i]) cyc(0, 0, xs[i], 5, 1);
        // gradient
        pattern_sel = 2'd1;
        while (m_fc < 7) frame_rand();
        cyc(0, 0, 200, 100, 1);
        // mid-frame select change must not show until the next frame
        pattern_sel = 2'd2;
        repeat (4) rand_pix();
        cyc(0, 0, 200, 100, 1);
        while (m_fc < 31) frame_rand();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 16, 0, 1);
        cyc(0, 1, 16, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 16, 0, 1);
        // bouncing box edges
        pattern_sel = 2'd3;
        while (m_fc < 50) frame_rand();
        bx = m_bx; by = m_by;
        cyc(0, 0, bx, by, 1);
        cyc(0, 0, bx + BOX_SIZE - 1, by + BOX_SIZE - 1, 1);
        cyc(0, 0, bx + BOX_SIZE, by, 1);
        cyc(0, 0, bx - 1, by + 10, 1);
        repeat (8) cyc(0, 0, $urandom_range(0, 1023), $urandom_range(0, 511), 0);
        while (m_fc < 100) begin
            pattern_sel = 2'($urandom_range(0, 3));
            frame_rand();
        end
        // mid-operation reset, including one coinciding with new_frame
        cyc(1, 0, 20, 20, 1);
        cyc(1, 1, 20, 20, 1);
        cyc(0, 0, 20, 20, 1);
        repeat (230) begin
            pattern_sel = 2'($urandom_range(0, 3));
            frame_rand();
        end
        @(negedge cclk);
        data_ena = 1'b0; new_frame = 1'b0;
        repeat (2) @(posedge cclk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tft_pattern_gen.md
Name: tft_pattern_gen

Overview:
Pixel-source stage directly upstream of tft_driver. It consumes the driver's scan position (x, y), new_frame and data-enable, and returns 24-bit RGB for the current pixel. It holds its own frame-level state: a frame counter, a latched pattern select, and a bouncing-box position updated once per frame. This gives the panel a self-contained animated test source for bring-up.

Parameters:
H_ACTIVE, 480, active pixels per line; x >= H_ACTIVE renders black
V_ACTIVE, 272, active lines per frame; y >= V_ACTIVE renders black
BOX_SIZE, 32, bouncing-box edge length in pixels
BOX_STEP, 2, box displacement per frame on each axis, in pixels

Ports:
cclk  input  1  system clock; the only clock; all inputs are synchronous to it
rst  input  1  synchronous, active-high reset
pattern_sel  input  2  requested pattern; takes effect at the next frame boundary
x  input  10  current pixel column from tft_driver
y  input  9  current pixel row from tft_driver
new_frame  input  1  one-cycle pulse at the start of each frame, from tft_driver
data_ena  input  1  pixel-valid qualifier, mirrors tft_data_ena
red  output  8  red component, registered
green  output  8  green component, registered
blue  output  8  blue component, registered
frame_count  output  16  frames elapsed since reset
box_x  output  10  box left edge
box_y  output  9  box top edge

Behaviour:
- Reset (rst=1 at a cclk edge):
  - red/green/blue=0, frame_count=0, latched pattern=0, box_x=0, box_y=0, dir_x=+, dir_y=+.
  - Reset applied mid-frame takes effect at the next edge; any new_frame pulse in the same cycle is ignored.
- Frame update, on a cycle with new_frame=1 and rst=0:
  - frame_count increments and wraps from 0xFFFF to 0.
  - pattern_sel is latched.
  - The box steps on each axis independently. X-axis rule (Y identical, using V_ACTIVE):
    - Moving +: if box_x+BOX_STEP >= H_ACTIVE-BOX_SIZE, then box_x=H_ACTIVE-BOX_SIZE and dir_x becomes -; otherwise box_x += BOX_STEP.
    - Moving -: if box_x <= BOX_STEP, then box_x=0 and dir_x becomes +; otherwise box_x -= BOX_STEP.
  - Compute each axis with one extra bit so no intermediate value wraps.
- Pixel path:
  - Exactly 1 cclk of latency: the RGB registered at edge N reflects x, y, data_ena sampled at edge N, using box/frame state before any update at that same edge.
  - If data_ena=0, or x>=H_ACTIVE, or y>=V_ACTIVE, RGB=000000.
  - Pattern 0, colour bars. bar=x/(H_ACTIVE/8), giving bars 0..7 in this order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Division is by constant compare; no divider.
  - Pattern 1, gradient: red=x[8:1], green=y[8:1], blue=frame_count[7:0].
  - Pattern 2, checkerboard: FFFFFF when x[4]^y[4]^frame_count[5]=1, else 000000. The phase inverts every 32 frames.
  - Pattern 3, bouncing box: FF0000 when box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE, else 404040.
- Simultaneous events:
  - A pattern_sel change between frames has no effect on the pixel path until the next new_frame.
  - new_frame and data_ena=1 in the same cycle: the pixel uses the old state.
- Timing: combinational depth is bounded to one compare-and-mux stage plus the output register, so the block meets the cclk target used by tft_driver.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with data_ena=1, x=10, y=10 -> RGB=000000, frame_count=0, box_x=0, box_y=0; after release with pattern 0, next-cycle RGB=FFFFFF.
- Colour bars: pattern_sel=0, pulse new_frame, then sweep y=5 over x=0,59,60,300,479,480 -> FFFFFF, FFFFFF, FFFF00, FF0000, 000000, 000000, each exactly 1 cycle after the x is applied.
- Box bounce: apply 230 new_frame pulses -> box_x walks 0,2,...,448 (reached on frame 224) then 446, 444, ...; box_y reaches 240 on frame 120, then descends; on the X axis no value >448 ever appears and there is no underflow below 0.
- Box render: pattern 3, box_x=100, box_y=50 -> (100,50)=FF0000, (131,81)=FF0000, (132,50)=404040, (99,60)=404040.
- Pattern latch and checker phase: set pattern_sel=2 mid-frame -> output stays on the old pattern until the next new_frame. At frame_count=31, (0,0) is 000000; at frame_count=32, (0,0) is FFFFFF; (16,0) is the complement of (0,0).
- Mid-operation reset and gating: assert rst at frame 100 while data_ena=1 -> all state returns to reset values on the next edge. data_ena=0 with any x, y -> RGB=000000. Pattern 1 at x=200, y=100, frame_count=7 -> RGB=64_32_07.
